// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic device among NUM_CTRL controllers.
// A grant is held for a controller's whole cyc and released with one dead cycle.
module wishbone_rr_arbiter #(
  parameter int NUM_CTRL   = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CTRL-1:0]            ctrl_cyc_i,
  input  logic [NUM_CTRL-1:0]            ctrl_stb_i,
  input  logic [NUM_CTRL-1:0]            ctrl_we_i,
  input  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_dat_i,
  output logic [NUM_CTRL-1:0]            ctrl_ack_o,
  output logic                           dev_cyc_o,
  output logic                           dev_stb_o,
  output logic                           dev_we_o,
  output logic [DATA_WIDTH-1:0]          dev_dat_o,
  input  logic                           dev_ack_i,
  output logic [NUM_CTRL-1:0]            grant_o
);

  localparam int PTR_W = $clog2(NUM_CTRL);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                state_q;
  logic [NUM_CTRL-1:0]   grant_q;
  logic [PTR_W-1:0]      ptr_q;

  logic                  sel_vld;
  logic [PTR_W-1:0]      sel_idx;
  logic [NUM_CTRL-1:0]   sel_oh;

  // Two passes: requesters above the pointer first, then wrap from 0 up to
  // the pointer itself, so the last owner ends up with lowest priority.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_oh  = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (!sel_vld && ctrl_cyc_i[k] && (k > int'(ptr_q))) begin
        sel_vld   = 1'b1;
        sel_idx   = PTR_W'(k);
        sel_oh[k] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (!sel_vld && ctrl_cyc_i[k]) begin
        sel_vld   = 1'b1;
        sel_idx   = PTR_W'(k);
        sel_oh[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_CTRL - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            state_q <= GRANTED;
            grant_q <= sel_oh;
            ptr_q   <= sel_idx;
          end
        end
        GRANTED: begin
          if (!(|(ctrl_cyc_i & grant_q))) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Routing is an AND-OR over the one-hot grant, so everything reads 0 while idle.
  always_comb begin
    dev_cyc_o = 1'b0;
    dev_stb_o = 1'b0;
    dev_we_o  = 1'b0;
    dev_dat_o = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (grant_q[k]) begin
        dev_cyc_o = ctrl_cyc_i[k];
        dev_stb_o = ctrl_stb_i[k];
        dev_we_o  = ctrl_we_i[k];
        dev_dat_o = ctrl_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ctrl_ack_o = grant_q & {NUM_CTRL{dev_ack_i}};
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Bench for wishbone_rr_arbiter: per-cycle vectors queued on drive, compared at the falling edge.
module tb_wishbone_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam logic [31:0] DDEF = 32'h445A2211;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   cyc, stb, we;
  logic [N*W-1:0] dat;
  logic [N-1:0]   cack;
  logic           dcyc, dstb, dwe;
  logic [W-1:0]   ddat;
  logic           dack;
  logic [N-1:0]   grant;

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(.NUM_CTRL(N), .DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ctrl_cyc_i(cyc), .ctrl_stb_i(stb), .ctrl_we_i(we), .ctrl_dat_i(dat),
    .ctrl_ack_o(cack),
    .dev_cyc_o(dcyc), .dev_stb_o(dstb), .dev_we_o(dwe), .dev_dat_o(ddat),
    .dev_ack_i(dack), .grant_o(grant)
  );

  typedef struct {
    logic       rst;
    logic [3:0] cyc, stb, we;
    logic [31:0] dat;
    logic       ack;
    logic [3:0] g;
    logic       dc, ds, dw;
    logic [7:0] dd;
    logic [3:0] ca;
  } vec_t;

  vec_t sb[$];
  int   id_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vid = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] c, s, w,
                              input logic [31:0] d, input logic a,
                              input logic [3:0] g, input logic dc, ds, dw,
                              input logic [7:0] dd, input logic [3:0] ca);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.dat = d; v.ack = a;
    v.g = g; v.dc = dc; v.ds = ds; v.dw = dw; v.dd = dd; v.ca = ca;
    return v;
  endfunction

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d.%s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; cyc = v.cyc; stb = v.stb; we = v.we; dat = v.dat; dack = v.ack;
    sb.push_back(v);
    id_q.push_back(vid);
    vid++;
  endtask

  always @(negedge clk) begin
    vec_t e;
    int   id;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      id = id_q.pop_front();
      chk(id, "grant",    32'(grant), 32'(e.g));
      chk(id, "dev_cyc",  32'(dcyc),  32'(e.dc));
      chk(id, "dev_stb",  32'(dstb),  32'(e.ds));
      chk(id, "dev_we",   32'(dwe),   32'(e.dw));
      chk(id, "dev_dat",  32'(ddat),  32'(e.dd));
      chk(id, "ctrl_ack", 32'(cack),  32'(e.ca));
      chk(id, "grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk(id, "ack_in_grant",  32'(cack & ~grant), 32'd0);
      chk(id, "cyc_needs_grant", 32'(dcyc && (grant == '0)), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[15];

  initial begin
    logic [31:0] dv;
    int order[5];
    dv = DDEF;
    order = '{0, 1, 2, 3, 0};

    // Single request, spurious idle ack, then contention after a reset.
    tbl[0]  = mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
    tbl[1]  = mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
    tbl[2]  = mk(0, 4'b0100, 4'b0100, 4'b0100, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
    tbl[3]  = mk(0, 4'b0100, 4'b0100, 4'b0100, DDEF, 1, 4'b0100, 1, 1, 1, 8'h5A, 4'b0100);
    tbl[4]  = mk(0, 4'b0100, 4'b0000, 4'b0000, DDEF, 0, 4'b0100, 1, 0, 0, 8'h5A, 4'b0000);
    tbl[5]  = mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0100, 0, 0, 0, 8'h5A, 4'b0000);
    tbl[6]  = mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
    tbl[7]  = mk(1, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
    tbl[8]  = mk(0, 4'b0101, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
    tbl[9]  = mk(0, 4'b0101, 4'b0001, 4'b0000, DDEF, 1, 4'b0001, 1, 1, 0, 8'h11, 4'b0001);
    tbl[10] = mk(0, 4'b0100, 4'b0000, 4'b0000, DDEF, 0, 4'b0001, 0, 0, 0, 8'h11, 4'b0000);
    tbl[11] = mk(0, 4'b0100, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
    tbl[12] = mk(0, 4'b0100, 4'b0100, 4'b0000, DDEF, 1, 4'b0100, 1, 1, 0, 8'h5A, 4'b0100);
    tbl[13] = mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0100, 0, 0, 0, 8'h5A, 4'b0000);
    tbl[14] = mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);

    rst = 1'b1; cyc = '0; stb = '0; we = '0; dat = DDEF; dack = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 15; i++) step(tbl[i]);

    // Rotation: all four hold cyc; each drops it after one acked write.
    step(mk(1, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh;
      logic [7:0] sl;
      oh = 4'b0001 << order[i];
      sl = dv[order[i]*8 +: 8];
      step(mk(0, 4'b1111, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
      step(mk(0, 4'b1111, oh, oh, DDEF, 1, oh, 1, 1, 1, sl, oh));
      step(mk(0, 4'b1111 & ~oh, 4'b0000, 4'b0000, DDEF, 0, oh, 0, 0, 0, sl, 4'b0000));
    end

    // Bus lock: controller 1 does five transfers while controller 3 waits.
    step(mk(1, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    step(mk(0, 4'b1010, 4'b0000, 4'b0000, 32'hEE000100, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    for (int n = 1; n <= 5; n++) begin
      logic [31:0] d;
      d = {8'hEE, 8'h00, 8'(n), 8'h00};
      step(mk(0, 4'b1010, 4'b1010, 4'b1000, d, 1, 4'b0010, 1, 1, 0, 8'(n), 4'b0010));
    end
    step(mk(0, 4'b1000, 4'b1000, 4'b1000, 32'hEE000500, 0, 4'b0010, 0, 0, 0, 8'h05, 4'b0000));
    step(mk(0, 4'b1000, 4'b1000, 4'b1000, 32'hEE000500, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    step(mk(0, 4'b1000, 4'b1000, 4'b1000, 32'hEE000500, 1, 4'b1000, 1, 1, 1, 8'hEE, 4'b1000));
    step(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'hEE000500, 0, 4'b1000, 0, 0, 0, 8'hEE, 4'b0000));
    step(mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));

    // Reset while controller 2 owns the bus; pointer returns to controller 0 first.
    step(mk(1, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    step(mk(0, 4'b0100, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    step(mk(0, 4'b0100, 4'b0100, 4'b0100, DDEF, 0, 4'b0100, 1, 1, 1, 8'h5A, 4'b0000));
    step(mk(1, 4'b0110, 4'b0100, 4'b0100, DDEF, 1, 4'b0100, 1, 1, 1, 8'h5A, 4'b0100));
    step(mk(0, 4'b0110, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    step(mk(0, 4'b0110, 4'b0000, 4'b0000, DDEF, 0, 4'b0010, 1, 0, 0, 8'h22, 4'b0000));
    step(mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0010, 0, 0, 0, 8'h22, 4'b0000));
    step(mk(0, 4'b0000, 4'b0000, 4'b0000, DDEF, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));

    @(posedge clk);
    @(negedge clk);
    #1;
    chk(vid, "scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
